// File: rtl/pll_phase_stepper_if.sv
// Request channel into the PLL phase stepper: one phase-shift job per valid/ready transfer.
interface pll_phase_stepper_if #(
    parameter int STEP_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_counter_sel;
    logic              req_up_down;
    logic [STEP_W-1:0] req_steps;

    modport master (
        output req_valid,
        output req_counter_sel,
        output req_up_down,
        output req_steps,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_counter_sel,
        input  req_up_down,
        input  req_steps,
        output req_ready
    );
endinterface

// File: rtl/pll_phase_stepper.sv
// Drives the PLL dynamic phase-shift port one step at a time, absorbing the per-step
// phase_done low/high handshake and reporting completion, step count and error status.
//
// state     | meaning
// IDLE      | waiting for a request; ready when PLL locked and phase_done high
// SETUP     | cntsel/updn settled, phase_enable low for one cycle
// PULSE     | phase_enable high for PULSE_CYCLES cycles
// WAIT_LOW  | waiting for PLL to drop phase_done
// WAIT_HIGH | waiting for PLL to raise phase_done (step complete)
// FINISH    | one cycle before IDLE; done_pulse follows
module pll_phase_stepper #(
    parameter int STEP_W         = 8,
    parameter int PULSE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                system_clk,
    input  logic                system_reset,
    input  logic                pll_locked,
    pll_phase_stepper_if.slave  req,
    output logic                busy,
    output logic                done_pulse,
    output logic [1:0]          err,
    output logic [STEP_W-1:0]   steps_done,
    output logic [4:0]          counter_sel,
    output logic                phase_up_down,
    output logic                phase_enable,
    input  logic                phase_done
);

    localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LOAD   = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT_LOW,
        WAIT_HIGH,
        FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   steps_lat_q, steps_lat_d;
    logic                seen_low_q, seen_low_d;
    logic [PULSE_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [1:0]          err_d;
    logic [STEP_W-1:0]   steps_done_d;
    logic [STEP_W-1:0]   step_next;
    logic [4:0]          counter_sel_d;
    logic                up_down_d;
    logic                ready_int;
    logic                lock_lost;

    assign ready_int     = (state_q == IDLE) && pll_locked && phase_done;
    assign req.req_ready = ready_int;
    assign busy          = (state_q != IDLE);
    assign step_next     = steps_done + STEP_W'(1);
    assign lock_lost     = !pll_locked && (state_q inside {SETUP, PULSE, WAIT_LOW, WAIT_HIGH});

    always_comb begin
        state_d       = state_q;
        steps_lat_d   = steps_lat_q;
        seen_low_d    = seen_low_q;
        pulse_cnt_d   = pulse_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_d         = err;
        steps_done_d  = steps_done;
        counter_sel_d = counter_sel;
        up_down_d     = phase_up_down;

        case (state_q)
            IDLE: begin
                if (req.req_valid && ready_int) begin
                    steps_lat_d   = req.req_steps;
                    counter_sel_d = req.req_counter_sel;
                    up_down_d     = req.req_up_down;
                    err_d         = 2'b00;
                    steps_done_d  = '0;
                    state_d       = (req.req_steps == '0) ? FINISH : SETUP;
                end
            end
            SETUP: begin
                seen_low_d  = 1'b0;
                pulse_cnt_d = PULSE_LOAD;
                state_d     = PULSE;
            end
            PULSE: begin
                if (!phase_done) seen_low_d = 1'b1;
                if (pulse_cnt_q == '0) begin
                    tmo_cnt_d = TMO_LOAD;
                    // PLL already acknowledged during the pulse: skip the low wait.
                    state_d   = (seen_low_q || !phase_done) ? WAIT_HIGH : WAIT_LOW;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
                end
            end
            WAIT_LOW: begin
                tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                if (!phase_done) begin
                    state_d = WAIT_HIGH;
                end else if (tmo_cnt_q == '0) begin
                    err_d[0] = 1'b1;
                    state_d  = FINISH;
                end
            end
            WAIT_HIGH: begin
                tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                if (phase_done) begin
                    if (steps_done != steps_lat_q) steps_done_d = step_next;
                    state_d = (step_next == steps_lat_q) ? FINISH : SETUP;
                end else if (tmo_cnt_q == '0) begin
                    err_d[0] = 1'b1;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Losing lock overrides timeout and step completion in the same cycle.
        if (lock_lost) begin
            state_d      = FINISH;
            err_d        = err | 2'b10;
            steps_done_d = steps_done;
        end
    end

    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            state_q       <= IDLE;
            steps_lat_q   <= '0;
            seen_low_q    <= 1'b0;
            pulse_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            err           <= 2'b00;
            steps_done    <= '0;
            counter_sel   <= 5'b00000;
            phase_up_down <= 1'b1;
            phase_enable  <= 1'b0;
            done_pulse    <= 1'b0;
        end else begin
            state_q       <= state_d;
            steps_lat_q   <= steps_lat_d;
            seen_low_q    <= seen_low_d;
            pulse_cnt_q   <= pulse_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            err           <= err_d;
            steps_done    <= steps_done_d;
            counter_sel   <= counter_sel_d;
            phase_up_down <= up_down_d;
            phase_enable  <= (state_d == PULSE);
            done_pulse    <= (state_q == FINISH);
        end
    end

endmodule

// File: doc/pll_phase_stepper.md
# pll_phase_stepper

Sequencer that sits directly downstream of the PLL-control IO registers and drives the PLL dynamic phase-shift port. It accepts a request (counter select, direction, step count) via valid/ready, issues one phase-enable pulse per step, waits out the PLL's phase_done low/high handshake each time, and reports completion, step count and error status. It removes per-step PLL handshaking from the bus-facing register logic.

## Interface
- STEP_W, 8, width of step count and steps_done
- PULSE_CYCLES, 2, cycles phase_enable is held high per step (>=1)
- TIMEOUT_CYCLES, 1023, max cycles waiting for phase_done per step (>=2)

- system_clk  in  1  sole clock
- system_reset  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL lock status
- req_valid  in  1  request present
- req_ready  out  1  combinational: state==IDLE && pll_locked && phase_done
- req_counter_sel  in  5  PLL counter to shift
- req_up_down  in  1  1=up, 0=down
- req_steps  in  STEP_W  number of steps; 0 = no-op
- busy  out  1  state!=IDLE
- done_pulse  out  1  one-cycle completion strobe
- err  out  2  bit0 timeout, bit1 lock lost; sticky until next accepted request
- steps_done  out  STEP_W  steps completed in current/last request
- counter_sel  out  5  to PLL cntsel
- phase_up_down  out  1  to PLL updn
- phase_enable  out  1  to PLL phasestep
- phase_done  in  1  from PLL; low while a step is in progress

## Operation
- Reset values: state IDLE, counter_sel 5'b00000, phase_up_down 1, phase_enable 0, done_pulse 0, err 2'b00, steps_done 0, internal counters 0.
- States: IDLE, SETUP, PULSE, WAIT_LOW, WAIT_HIGH, FINISH.
- IDLE: on req_valid&&req_ready latch request, load counter_sel/phase_up_down, clear steps_done and err. req_steps==0 -> FINISH, else -> SETUP.
- SETUP: one cycle, cntsel/updn stable, phase_enable 0 -> PULSE.
- PULSE: phase_enable 1 for exactly PULSE_CYCLES cycles. Record seen_low if phase_done==0 in any PULSE cycle. Exit -> WAIT_HIGH if seen_low else WAIT_LOW; timeout counter cleared on exit.
- WAIT_LOW: phase_done==0 -> WAIT_HIGH.
- WAIT_HIGH: phase_done==1 -> steps_done+1; if new value==latched steps -> FINISH else SETUP.
- Timeout: counter increments each cycle in WAIT_LOW/WAIT_HIGH; reaching TIMEOUT_CYCLES sets err[0], -> FINISH, remaining steps abandoned.
- Lock loss: pll_locked==0 in any state except IDLE/FINISH sets err[1], forces phase_enable 0, -> FINISH in the next cycle. Takes precedence over timeout and step completion in the same cycle.
- FINISH: done_pulse 1 for one cycle -> IDLE.
- counter_sel/phase_up_down only change at acceptance; hold between requests.
- steps_done saturates at latched step count; no wrap.
- req_* ignored whenever req_ready==0.

## Timing
- Acceptance in cycle T: SETUP in T+1 with new counter_sel/phase_up_down visible; phase_enable high T+2..T+1+PULSE_CYCLES.
- Zero-step request: done_pulse in T+2, busy high T+1 only.
- Per step, with PLL dropping phase_done a cycles after pulse ends and raising it b cycles later: step period = 1+PULSE_CYCLES+a+b+1 cycles; steps_done increments the cycle after phase_done seen high.
- done_pulse asserted the cycle after the last step's WAIT_HIGH exit; req_ready can be high the cycle after done_pulse.
- system_reset mid-operation: all outputs to reset values next edge, phase_enable dropped immediately (no pulse completion), no done_pulse.
- All outputs registered except req_ready and busy.

## Test plan
- Reset, idle PLL model (phase_done=1, locked=1): req_steps=0, sel=5'd3 -> counter_sel=3 at T+1, done_pulse at T+2, no phase_enable, err=0.
- req_steps=3, up=0, sel=5'd1, PLL drops phase_done 2 cycles after pulse, raises 4 later -> three 2-cycle phase_enable pulses, steps_done 1,2,3, one done_pulse, phase_up_down=0.
- PLL drops phase_done during PULSE (seen_low path) -> no WAIT_LOW stall, step completes, steps_done=1.
- PLL never drops phase_done, TIMEOUT_CYCLES=16, req_steps=5 -> err=2'b01, steps_done=0, done_pulse 16 cycles into wait.
- pll_locked falls during second step of 4 -> phase_enable 0 next cycle, err=2'b10, steps_done=1, done_pulse once; req_ready stays 0 until locked returns.
- system_reset asserted during PULSE -> phase_enable 0, busy 0, counter_sel 0, phase_up_down 1 next cycle, no done_pulse.
